uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer_if.sv | 24 ++
 rtl/uart_tx_framer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// Parallel-side bundle of the UART transmit framer: frame request inputs and
// the serial line / busy status coming back.
interface uart_tx_framer_if #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 6
);
  logic [PWIDTH-1:0] prescale;
  logic [DWIDTH-1:0] p_data;
  logic              data_valid;
  logic              par_en;
  logic              par_typ;
  logic              tx_out;
  logic              busy;

  modport master (
    output prescale, p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  prescale, p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DWIDTH data bits LSB first, optional
// even/odd parity, one stop bit; each bit lasts max(prescale,1) clk cycles.
module uart_tx_framer #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_framer_if.slave bus
);
  localparam int BWIDTH = $clog2(DWIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PWIDTH-1:0]   presc_q, presc_d;
  logic [PWIDTH-1:0]   cnt_q, cnt_d;
  logic [PWIDTH-1:0]   last_cnt_s;
  logic [BWIDTH-1:0]   bit_q, bit_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                bit_done_s;

  function automatic logic calc_parity(input logic [DWIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // A prescale of zero behaves like one cycle per bit.
  assign last_cnt_s = (presc_q == '0) ? '0 : presc_q - PWIDTH'(1);
  assign bit_done_s = (cnt_q == last_cnt_s);

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

  // State register and latched frame parameters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; tx/busy are computed for the coming cycle so the outputs stay registered.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_d     = bit_done_s ? '0 : cnt_q + PWIDTH'(1);
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.data_valid) begin
          state_d   = START;
          presc_d   = bus.prescale;
          data_d    = bus.p_data;
          par_en_d  = bus.par_en;
          par_bit_d = calc_parity(bus.p_data, bus.par_typ);
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (bit_q == BWIDTH'(DWIDTH - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d  = bit_q + BWIDTH'(1);
            data_d = data_q >> 1;
            tx_d   = data_d[0];
          end
        end else begin
          tx_d = data_q[0];
        end
      end
      PARITY: begin
        if (bit_done_s) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d = par_bit_q;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          bit_d   = '0;
          data_d  = '0;
        end else begin
          busy_d = 1'b1;
        end
        tx_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench: each frame is rebuilt as a list of line levels from the
// byte and parity settings and compared cycle by cycle with the serial output.
module tb_uart_tx_framer;
  localparam int DW = 8;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_tx_framer_if #(.DWIDTH(DW), .PWIDTH(PW)) bus ();

  uart_tx_framer #(.DWIDTH(DW), .PWIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after the frame.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic [PW-1:0] ps, input bit hold,
                            output int busy_n, output logic par_obs);
    bit q[$];
    int p;
    int n;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    if (pe) q.push_back((^d) ^ pt);
    q.push_back(1'b1);
    p = (ps == 0) ? 1 : int'(ps);
    n = q.size() * p;
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.prescale   = ps;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.data_valid = 1'b0;
    busy_n  = 0;
    par_obs = 1'bx;
    for (int c = 0; c < n; c++) begin
      bus.p_data   = DW'($urandom);
      bus.par_en   = 1'($urandom);
      bus.par_typ  = 1'($urandom);
      bus.prescale = PW'($urandom);
      @(negedge clk);
      chk("tx", 32'(bus.tx_out), 32'(q[c / p]));
      chk("busy", 32'(bus.busy), 32'd1);
      if (bus.busy) busy_n++;
      if (pe && c == (DW + 1) * p) par_obs = bus.tx_out;
    end
    @(negedge clk);
    chk("idle_tx", 32'(bus.tx_out), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int   bn;
    logic po;
    logic [DW-1:0] rd;
    logic [PW-1:0] rp;
    logic re, rt;
    bus.p_data     = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.prescale   = '0;
    bus.data_valid = 1'b1;

    // Reset state; a request while in reset must not be taken.
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(bus.tx_out), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    bus.data_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    send_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, bn, po);
    chk("len_a5_p8", 32'(bn), 32'd80);

    send_frame(8'h07, 1'b1, 1'b0, 6'd4, 1'b0, bn, po);
    chk("par_07_even", 32'(po), 32'd1);
    chk("len_07_par", 32'(bn), 32'd44);
    send_frame(8'h07, 1'b1, 1'b1, 6'd4, 1'b0, bn, po);
    chk("par_07_odd", 32'(po), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b0, 6'd4, 1'b0, bn, po);
    chk("par_a5_even", 32'(po), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1, 6'd4, 1'b0, bn, po);
    chk("par_a5_odd", 32'(po), 32'd1);

    send_frame(8'hFF, 1'b0, 1'b0, 6'd0, 1'b0, bn, po);
    chk("len_ps0", 32'(bn), 32'd10);
    send_frame(8'hFF, 1'b0, 1'b0, 6'd1, 1'b0, bn, po);
    chk("len_ps1", 32'(bn), 32'd10);

    // Back-to-back with data_valid held high and inputs churning mid-frame.
    for (int k = 0; k < 4; k++) begin
      rd = DW'($urandom);
      send_frame(rd, 1'b1, 1'(k), 6'd2, (k != 3), bn, po);
      chk("len_b2b", 32'(bn), 32'd22);
    end

    // Reset in the middle of data bit 3, then a fresh frame.
    bus.p_data     = 8'h00;
    bus.par_en     = 1'b0;
    bus.prescale   = 6'd4;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("pre_abort_tx", 32'(bus.tx_out), 32'd0);
    chk("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_tx", 32'(bus.tx_out), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    bus.data_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("in_rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    bus.data_valid = 1'b0;
    @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0, 6'd4, 1'b0, bn, po);
    chk("len_3c", 32'(bn), 32'd40);

    // Randomised frames.
    for (int k = 0; k < 12; k++) begin
      rd = DW'($urandom);
      re = 1'($urandom);
      rt = 1'($urandom);
      rp = PW'($urandom_range(0, 5));
      send_frame(rd, re, rt, rp, 1'($urandom), bn, po);
      chk("len_rand", 32'(bn), 32'((DW + 2 + int'(re)) * ((rp == 0) ? 1 : int'(rp))));
      bus.data_valid = 1'b0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
